// File: rtl/rect_drag_ctl.sv
// Drag-and-drop position controller for the rectangle image.
// Follows the pointer while held; updates only on vblank rising edges.
module rect_drag_ctl #(
    parameter int RECT_W   = 48,
    parameter int RECT_H   = 64,
    parameter int SCREEN_W = 800,
    parameter int SCREEN_H = 600,
    parameter int X_INIT   = 0,
    parameter int Y_INIT   = 0
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        rect_clicked,
    input  logic        mouse_left,
    input  logic [11:0] xpos_mouse,
    input  logic [11:0] ypos_mouse,
    input  logic        vblnk_in,
    output logic [11:0] xpos_rect,
    output logic [11:0] ypos_rect,
    output logic        dragging
);

    localparam logic signed [12:0] X_LIM = 13'(SCREEN_W - RECT_W);
    localparam logic signed [12:0] Y_LIM = 13'(SCREEN_H - RECT_H);
    localparam logic [11:0]        X_RST = 12'(X_INIT);
    localparam logic [11:0]        Y_RST = 12'(Y_INIT);

    typedef enum logic {
        IDLE = 1'b0,
        DRAG = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               vblnk_d;
    logic               tick;
    logic               load_off;
    logic               load_pos;
    logic signed [12:0] off_x;
    logic signed [12:0] off_y;
    logic signed [12:0] grab_x;
    logic signed [12:0] grab_y;
    logic signed [12:0] tx;
    logic signed [12:0] ty;
    logic [11:0]        x_clamp;
    logic [11:0]        y_clamp;

    // Saturate a signed target into [0, lim].
    function automatic logic [11:0] clamp(
        input logic signed [12:0] v,
        input logic signed [12:0] lim
    );
        if (v < 13'sd0) begin
            return 12'd0;
        end else if (v > lim) begin
            return lim[11:0];
        end else begin
            return v[11:0];
        end
    endfunction

    assign tick = vblnk_in & ~vblnk_d;

    // Grab offset and drag target arithmetic, all 13-bit signed.
    always_comb begin
        grab_x  = $signed({1'b0, xpos_mouse}) - $signed({1'b0, xpos_rect});
        grab_y  = $signed({1'b0, ypos_mouse}) - $signed({1'b0, ypos_rect});
        tx      = $signed({1'b0, xpos_mouse}) - off_x;
        ty      = $signed({1'b0, ypos_mouse}) - off_y;
        x_clamp = clamp(tx, X_LIM);
        y_clamp = clamp(ty, Y_LIM);
    end

    // Next-state logic; release beats a same-cycle frame tick.
    always_comb begin
        state_nxt = state;
        load_off  = 1'b0;
        load_pos  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rect_clicked && mouse_left) begin
                    state_nxt = DRAG;
                    load_off  = 1'b1;
                end
            end
            DRAG: begin
                if (!mouse_left) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    load_pos = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and drag flag.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state    <= IDLE;
            dragging <= 1'b0;
        end else begin
            state    <= state_nxt;
            dragging <= (state_nxt == DRAG);
        end
    end

    // Vblank edge detector.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vblnk_d <= 1'b0;
        end else begin
            vblnk_d <= vblnk_in;
        end
    end

    // Offsets are captured only when a drag starts.
    always_ff @(posedge pclk) begin
        if (rst) begin
            off_x <= '0;
            off_y <= '0;
        end else if (load_off) begin
            off_x <= grab_x;
            off_y <= grab_y;
        end
    end

    // Rectangle position, moved only on frame ticks while dragging.
    always_ff @(posedge pclk) begin
        if (rst) begin
            xpos_rect <= X_RST;
            ypos_rect <= Y_RST;
        end else if (load_pos) begin
            xpos_rect <= x_clamp;
            ypos_rect <= y_clamp;
        end
    end

endmodule

// File: tb/tb_rect_drag_ctl.sv
// Self-checking bench for rect_drag_ctl.
// Directed scenarios plus random traffic against a behavioural model.
module tb_rect_drag_ctl;

    logic        pclk;
    logic        rst;
    logic        rect_clicked;
    logic        mouse_left;
    logic [11:0] xpos_mouse;
    logic [11:0] ypos_mouse;
    logic        vblnk_in;
    logic [11:0] xpos_rect;
    logic [11:0] ypos_rect;
    logic        dragging;

    int checks = 0;
    int errors = 0;

    // reference model state
    int  m_x, m_y, m_offx, m_offy;
    bit  m_drag, m_vprev;

    rect_drag_ctl dut (
        .pclk        (pclk),
        .rst         (rst),
        .rect_clicked(rect_clicked),
        .mouse_left  (mouse_left),
        .xpos_mouse  (xpos_mouse),
        .ypos_mouse  (ypos_mouse),
        .vblnk_in    (vblnk_in),
        .xpos_rect   (xpos_rect),
        .ypos_rect   (ypos_rect),
        .dragging    (dragging)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wrap13(input int v);
        int r;
        r = v & 8191;
        if (r >= 4096) r -= 8192;
        return r;
    endfunction

    function automatic int sat(input int v, input int lim);
        if (v < 0) return 0;
        if (v > lim) return lim;
        return v;
    endfunction

    // Apply one cycle of inputs, advance model, compare outputs.
    task automatic cyc(input bit r, input bit rc, input bit ml,
                       input int xm, input int ym, input bit vb,
                       input string tag);
        bit tick;
        @(negedge pclk);
        rst          = r;
        rect_clicked = rc;
        mouse_left   = ml;
        xpos_mouse   = 12'(xm);
        ypos_mouse   = 12'(ym);
        vblnk_in     = vb;
        @(posedge pclk);
        tick = vb && !m_vprev;
        if (r) begin
            m_x = 0; m_y = 0; m_offx = 0; m_offy = 0;
            m_drag = 0; m_vprev = 0;
        end else begin
            m_vprev = vb;
            if (!m_drag) begin
                if (rc && ml) begin
                    m_offx = xm - m_x;
                    m_offy = ym - m_y;
                    m_drag = 1;
                end
            end else if (!ml) begin
                m_drag = 0;
            end else if (tick) begin
                m_x = sat(wrap13(xm - m_offx), 800 - 48);
                m_y = sat(wrap13(ym - m_offy), 600 - 64);
            end
        end
        #1;
        chk({tag, ".x"}, int'(xpos_rect), m_x);
        chk({tag, ".y"}, int'(ypos_rect), m_y);
        chk({tag, ".drag"}, int'(dragging), int'(m_drag));
    endtask

    initial begin
        rst = 1; rect_clicked = 0; mouse_left = 0;
        xpos_mouse = 0; ypos_mouse = 0; vblnk_in = 0;
        m_x = 0; m_y = 0; m_offx = 0; m_offy = 0;
        m_drag = 0; m_vprev = 0;

        // reset
        cyc(1, 0, 0, 0, 0, 0, "rst");
        cyc(1, 0, 0, 0, 0, 0, "rst");
        chk("rst_x", int'(xpos_rect), 0);
        chk("rst_y", int'(ypos_rect), 0);
        chk("rst_drag", int'(dragging), 0);

        // place rect at (100,200) with a zero-offset drag
        cyc(0, 1, 1, 0, 0, 0, "place_grab");
        chk("grab_drag", int'(dragging), 1);
        cyc(0, 0, 1, 100, 200, 1, "place_tick");
        cyc(0, 0, 1, 100, 200, 0, "place_hold");
        cyc(0, 0, 0, 100, 200, 0, "place_rel");
        chk("place_x", int'(xpos_rect), 100);
        chk("place_y", int'(ypos_rect), 200);

        // grab with offset (10,30), move, tick
        cyc(0, 1, 1, 110, 230, 0, "grab");
        cyc(0, 1, 1, 300, 400, 0, "move");
        chk("no_tick_x", int'(xpos_rect), 100);
        cyc(0, 1, 1, 300, 400, 1, "tick");
        chk("drag_x", int'(xpos_rect), 290);
        chk("drag_y", int'(ypos_rect), 370);
        cyc(0, 1, 1, 300, 400, 0, "lo");

        // clamp low
        cyc(0, 1, 1, 5, 10, 1, "clo");
        chk("clamp_lo_x", int'(xpos_rect), 0);
        chk("clamp_lo_y", int'(ypos_rect), 0);
        cyc(0, 1, 1, 5, 10, 0, "lo");

        // clamp high
        cyc(0, 1, 1, 799, 599, 1, "chi");
        chk("clamp_hi_x", int'(xpos_rect), 752);
        chk("clamp_hi_y", int'(ypos_rect), 536);
        cyc(0, 1, 1, 400, 300, 0, "lo");

        // release in the tick cycle
        cyc(0, 0, 0, 400, 300, 1, "relprio");
        chk("relprio_drag", int'(dragging), 0);
        chk("relprio_x", int'(xpos_rect), 752);

        // frozen after release
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 50 + i * 10, 60 + i * 10, 0, "frz_lo");
            cyc(0, 0, 0, 50 + i * 10, 60 + i * 10, 1, "frz_hi");
        end
        chk("frozen_y", int'(ypos_rect), 536);

        // stale flag without button
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 20, 20, 0, "stale_lo");
            cyc(0, 1, 0, 20, 20, 1, "stale_hi");
        end
        chk("stale_drag", int'(dragging), 0);

        // reset mid-drag with button held
        cyc(0, 1, 1, 200, 200, 0, "g2");
        cyc(0, 1, 1, 300, 300, 1, "t2");
        cyc(1, 1, 1, 300, 300, 0, "rst_mid");
        chk("rst_mid_x", int'(xpos_rect), 0);
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 1, 300 + i, 300, i[0], "held");
        chk("held_drag", int'(dragging), 0);
        cyc(0, 1, 1, 300, 300, 0, "regrab");
        chk("regrab_drag", int'(dragging), 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, rc, ml, vb;
            int xm, ym;
            r  = ($urandom_range(0, 299) == 0);
            rc = ($urandom_range(0, 3) == 0);
            ml = ($urandom_range(0, 9) != 0);
            vb = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) begin
                xm = $urandom_range(0, 4095);
                ym = $urandom_range(0, 4095);
            end else begin
                xm = $urandom_range(0, 850);
                ym = $urandom_range(0, 650);
            end
            cyc(r, rc, ml, xm, ym, vb, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
